// File: rtl/register_file.sv
// 32 x 32-bit general-purpose register file with two combinational read
// ports, one clocked write port and same-cycle write-through bypass.
// Register 0 has no storage and always reads zero.
module register_file #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] read_reg_1,
   input  logic [ADDR_WIDTH-1:0] read_reg_2,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  reg_write,
   output logic [DATA_WIDTH-1:0] read_data_1,
   output logic [DATA_WIDTH-1:0] read_data_2
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   // Storage only for registers 1..Depth-1
   logic [DATA_WIDTH-1:0] regs_q [1:Depth-1];
   logic [DATA_WIDTH-1:0] regs_d [1:Depth-1];

   logic                  write_en;
   logic [DATA_WIDTH-1:0] stored_1;
   logic [DATA_WIDTH-1:0] stored_2;

   // Writes to register 0 are dropped here, so it never needs a flop
   assign write_en = reg_write && (write_reg != '0);

   // Next-state: load write_data into the addressed register
   always_comb begin
      for (int i = 1; i < Depth; i++) begin
         regs_d[i] = regs_q[i];
         if (write_en && (write_reg == ADDR_WIDTH'(i))) begin
            regs_d[i] = write_data;
         end
      end
   end

   // State update; synchronous reset takes priority over any write
   always_ff @(posedge clk) begin
      for (int i = 1; i < Depth; i++) begin
         if (!rst_n) begin
            regs_q[i] <= '0;
         end else begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Select stored contents for each read address (register 0 selects zero)
   always_comb begin
      stored_1 = '0;
      stored_2 = '0;
      for (int i = 1; i < Depth; i++) begin
         if (read_reg_1 == ADDR_WIDTH'(i)) begin
            stored_1 = regs_q[i];
         end
         if (read_reg_2 == ADDR_WIDTH'(i)) begin
            stored_2 = regs_q[i];
         end
      end
   end

   // Read port 1: reset, zero register, bypass, then stored value
   always_comb begin
      read_data_1 = stored_1;
      if (!rst_n || (read_reg_1 == '0)) begin
         read_data_1 = '0;
      end else if (reg_write && (write_reg == read_reg_1)) begin
         read_data_1 = write_data;
      end
   end

   // Read port 2: same priority as port 1
   always_comb begin
      read_data_2 = stored_2;
      if (!rst_n || (read_reg_2 == '0)) begin
         read_data_2 = '0;
      end else if (reg_write && (write_reg == read_reg_2)) begin
         read_data_2 = write_data;
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against a behavioural
// array model of the register contents.
module tb_register_file;

   logic        clk;
   logic        rst_n;
   logic [4:0]  read_reg_1;
   logic [4:0]  read_reg_2;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        reg_write;
   logic [31:0] read_data_1;
   logic [31:0] read_data_2;

   int unsigned n_checks;
   int unsigned n_errors;

   logic [31:0] model [32];

   register_file #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .read_reg_1 (read_reg_1),
      .read_reg_2 (read_reg_2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .reg_write  (reg_write),
      .read_data_1(read_data_1),
      .read_data_2(read_data_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected value of a read port from the current inputs and model contents
   function automatic logic [31:0] model_read(input logic [4:0] addr);
      if (!rst_n) return 32'h0;
      if (addr == 5'd0) return 32'h0;
      if (reg_write && write_reg == addr) return write_data;
      return model[addr];
   endfunction

   // Apply inputs, let them settle, compare both ports with the model
   task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
      rst_n      = rst;
      reg_write  = we;
      write_reg  = wr;
      write_data = wd;
      read_reg_1 = r1;
      read_reg_2 = r2;
      #2;
      check("port1_model", read_data_1, model_read(read_reg_1));
      check("port2_model", read_data_2, model_read(read_reg_2));
   endtask

   // Advance one edge and apply the architectural update to the model
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (reg_write && write_reg != 5'd0) begin
         model[write_reg] = write_data;
      end
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      rst_n = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
      read_reg_1 = '0; read_reg_2 = '0;
      @(negedge clk);

      // Reset held for two edges with a pending write to reg 5
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
         check("reset_rd1", read_data_1, 32'h0);
         check("reset_rd2", read_data_2, 32'h0);
         tick();
      end
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      check("post_reset_r5", read_data_1, 32'h0);

      // Basic write then read
      drive(1'b1, 1'b1, 5'd8, 32'h0000_1234, 5'd0, 5'd0);
      tick();
      drive(1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd0, 5'd0);
      tick();
      drive(1'b1, 1'b0, 5'd31, 32'h0, 5'd8, 5'd31);
      check("read_r8", read_data_1, 32'h0000_1234);
      check("read_r31", read_data_2, 32'hFFFF_FFFF);

      // Register zero ignores writes and never bypasses
      drive(1'b1, 1'b1, 5'd0, 32'hA5A5_A5A5, 5'd0, 5'd0);
      check("r0_same_cycle", read_data_1, 32'h0);
      tick();
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      check("r0_after_edge", read_data_1, 32'h0);

      // Bypass on both ports
      drive(1'b1, 1'b1, 5'd3, 32'h1111_1111, 5'd0, 5'd0);
      tick();
      drive(1'b1, 1'b1, 5'd3, 32'h2222_2222, 5'd3, 5'd3);
      check("bypass_rd1", read_data_1, 32'h2222_2222);
      check("bypass_rd2", read_data_2, 32'h2222_2222);
      tick();
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
      check("stored_rd1", read_data_1, 32'h2222_2222);
      check("stored_rd2", read_data_2, 32'h2222_2222);

      // Disabled write: no bypass, no store
      drive(1'b1, 1'b0, 5'd3, 32'h3333_3333, 5'd3, 5'd3);
      check("nowrite_bypass", read_data_1, 32'h2222_2222);
      tick();
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
      check("nowrite_store", read_data_2, 32'h2222_2222);

      // Load every register with its index, then reset with a write to reg 7
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 1'b1, 5'(i), 32'(i), 5'(i), 5'(32 - i));
         tick();
      end
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd17, 5'd31);
      check("loaded_r17", read_data_1, 32'd17);
      check("loaded_r31", read_data_2, 32'd31);
      drive(1'b0, 1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd9);
      tick();
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
         check("midreset_rd1", read_data_1, 32'h0);
         check("midreset_rd2", read_data_2, 32'h0);
      end

      // Randomized traffic; addresses often collide with write_reg to hit bypass
      for (int n = 0; n < 3000; n++) begin
         logic        r_rst;
         logic        r_we;
         logic [4:0]  r_wr;
         logic [31:0] r_wd;
         logic [4:0]  r_r1;
         logic [4:0]  r_r2;
         r_rst = ($urandom_range(0, 63) != 0);
         r_we  = $urandom_range(0, 1) == 1;
         r_wr  = 5'($urandom_range(0, 31));
         r_wd  = $urandom;
         r_r1  = ($urandom_range(0, 3) == 0) ? r_wr : 5'($urandom_range(0, 31));
         r_r2  = ($urandom_range(0, 3) == 0) ? r_wr : 5'($urandom_range(0, 31));
         drive(r_rst, r_we, r_wr, r_wd, r_r1, r_r2);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
